pcs_loopback: RTL

PCS_LOOPBACK -- requirements
Module: pcs_loopback

---
 rtl/pcs_loopback_pkg.sv | 22 ++
 rtl/lb_fifo.sv | 38 +++
 rtl/pcs_loopback.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pcs_loopback_pkg.sv
// Shared word definitions for the PCS loopback rate matcher.
// Flag fields are padded to the widest start vector; unused start bits stay zero.
package pcs_loopback_pkg;

   localparam int START_MAX = 2;

   typedef struct packed {
      logic                 ctrl;
      logic                 idle;
      logic [START_MAX-1:0] start;
      logic                 term;
      logic                 err;
   } pcs_flags_t;

   localparam pcs_flags_t IDLE_FLAGS  = '{ctrl: 1'b1, idle: 1'b1, start: '0, term: 1'b0, err: 1'b0};
   localparam pcs_flags_t ERROR_FLAGS = '{ctrl: 1'b1, idle: 1'b0, start: '0, term: 1'b0, err: 1'b1};

   function automatic int start_w(input bit is_10g);
      return is_10g ? 2 : 1;
   endfunction

endpackage

// File: rtl/lb_fifo.sv
// Elastic buffer storage; pointers carry one extra bit so full and empty differ.
module lb_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      fill
);

   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + ONE;
         if (rd) rptr <= rptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= wdata;
   end

   assign head = mem[rptr[AW-1:0]];
   assign fill = wptr - rptr;

endmodule

// File: rtl/pcs_loopback.sv
// PCS rx-to-tx loopback with idle delete/insert rate matching and underrun
// recovery; the tx word is a register loaded only when the transmitter samples.
module pcs_loopback
   import pcs_loopback_pkg::*;
#(
   parameter  bit IS_10G  = 1'b1,
   parameter  int DATA_W  = 64,
   parameter  int DEPTH   = 8,
   parameter  int HI_MARK = DEPTH - 2,
   parameter  int LO_MARK = 2,
   localparam int START_W = start_w(IS_10G),
   localparam int KEEP_W  = DATA_W / 8,
   localparam int FW      = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic               rx_valid_i,
   input  logic               rx_ctrl_v_i,
   input  logic               rx_idle_v_i,
   input  logic [START_W-1:0] rx_start_v_i,
   input  logic               rx_term_v_i,
   input  logic               rx_err_v_i,
   input  logic [DATA_W-1:0]  rx_data_i,
   input  logic [KEEP_W-1:0]  rx_keep_i,
   input  logic               tx_ready_i,
   output logic               tx_ctrl_v_o,
   output logic               tx_idle_v_o,
   output logic [START_W-1:0] tx_start_v_o,
   output logic               tx_term_v_o,
   output logic               tx_err_v_o,
   output logic [DATA_W-1:0]  tx_data_o,
   output logic [KEEP_W-1:0]  tx_keep_o,
   output logic [FW-1:0]      fill_o,
   output logic               del_o,
   output logic               ins_o,
   output logic               unf_o,
   output logic               ovf_o
);

   typedef struct packed {
      pcs_flags_t        f;
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
   } word_t;

   localparam word_t IDLE_WORD  = '{f: IDLE_FLAGS,  data: '0, keep: '0};
   localparam word_t ERROR_WORD = '{f: ERROR_FLAGS, data: '0, keep: '0};
   localparam logic [FW-1:0] HI   = FW'(HI_MARK);
   localparam logic [FW-1:0] LO   = FW'(LO_MARK);
   localparam logic [FW-1:0] FULL = FW'(DEPTH);

   word_t         rx_word, head, tx_q;
   logic [FW-1:0] fill;
   logic          rx_pkt, tx_pkt;
   logic          del, pop, wr_try, wr_en, full, ovf_hit;
   logic          del_q, ins_q, unf_q, ovf_q;

   always_comb begin
      rx_word                      = '0;
      rx_word.f.ctrl               = rx_ctrl_v_i;
      rx_word.f.idle               = rx_idle_v_i;
      rx_word.f.start[START_W-1:0] = rx_start_v_i;
      rx_word.f.term               = rx_term_v_i;
      rx_word.f.err                = rx_err_v_i;
      rx_word.data                 = rx_data_i;
      rx_word.keep                 = rx_keep_i;
   end

   // Idles are only dropped between packets, never inside one.
   assign del     = rx_valid_i && fill >= HI && rx_word == IDLE_WORD && !rx_pkt;
   assign pop     = tx_ready_i && (fill > LO || (fill != '0 && tx_pkt));
   assign full    = fill == FULL;
   assign wr_try  = rx_valid_i && !del;
   assign wr_en   = wr_try && (!full || pop);
   assign ovf_hit = wr_try && full && !pop;

   lb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(word_t))) u_fifo (
      .clk    (clk),
      .nreset (nreset),
      .wr     (wr_en),
      .wdata  (rx_word),
      .rd     (pop),
      .head   (head),
      .fill   (fill)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tx_q   <= IDLE_WORD;
         rx_pkt <= 1'b0;
         tx_pkt <= 1'b0;
         del_q  <= 1'b0;
         ins_q  <= 1'b0;
         unf_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         del_q <= del;
         ins_q <= 1'b0;
         unf_q <= 1'b0;
         if (ovf_hit) ovf_q <= 1'b1;
         if (rx_valid_i) begin
            if (rx_term_v_i)       rx_pkt <= 1'b0;
            else if (|rx_start_v_i) rx_pkt <= 1'b1;
         end
         if (tx_ready_i) begin
            if (pop) begin
               tx_q <= head;
               if (head.f.term)       tx_pkt <= 1'b0;
               else if (|head.f.start) tx_pkt <= 1'b1;
            end else if (!tx_pkt) begin
               tx_q  <= IDLE_WORD;
               ins_q <= 1'b1;
            end else begin
               // Buffer ran dry inside a packet: poison it and resync on idles.
               tx_q   <= ERROR_WORD;
               unf_q  <= 1'b1;
               tx_pkt <= 1'b0;
            end
         end
      end
   end

   assign tx_ctrl_v_o  = tx_q.f.ctrl;
   assign tx_idle_v_o  = tx_q.f.idle;
   assign tx_start_v_o = tx_q.f.start[START_W-1:0];
   assign tx_term_v_o  = tx_q.f.term;
   assign tx_err_v_o   = tx_q.f.err;
   assign tx_data_o    = tx_q.data;
   assign tx_keep_o    = tx_q.keep;
   assign fill_o       = fill;
   assign del_o        = del_q;
   assign ins_o        = ins_q;
   assign unf_o        = unf_q;
   assign ovf_o        = ovf_q;

endmodule
